// File: rtl/axi4_lite_reg_file.sv
// AXI4-Lite slave register file: parametrised count/width, read-only mask and reset values.
// Writable registers appear on o_regs; read-only registers return i_ro_val on reads.
module axi4_lite_reg_file #(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
  parameter int N_REGS = 16,
  parameter logic [N_REGS-1:0] RO_MASK = '0,
  parameter logic [N_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                       i_clk,
  input  logic                                       i_sync_rst,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]        i_s_axi_awaddr,
  input  logic                                       i_s_axi_awvalid,
  output logic                                       o_s_axi_awready,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]        i_s_axi_wdata,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0]      i_s_axi_wstrb,
  input  logic                                       i_s_axi_wvalid,
  output logic                                       o_s_axi_wready,
  output logic [1:0]                                 o_s_axi_bresp,
  output logic                                       o_s_axi_bvalid,
  input  logic                                       i_s_axi_bready,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]        i_s_axi_araddr,
  input  logic                                       i_s_axi_arvalid,
  output logic                                       o_s_axi_arready,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]        o_s_axi_rdata,
  output logic [1:0]                                 o_s_axi_rresp,
  output logic                                       o_s_axi_rvalid,
  input  logic                                       i_s_axi_rready,
  output logic [N_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] o_regs,
  output logic [N_REGS-1:0]                          o_wr_pulse,
  input  logic [N_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] i_ro_val
);

  localparam int AW     = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int DW     = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int IDX_W  = AW - OFS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic              aw_held, w_held;
  logic [AW-1:0]     aw_addr_q;
  logic [DW-1:0]     w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              commit;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [N_REGS-1:0] wr_sel, rd_sel, wr_allowed;
  logic              wr_ok, rd_ok;
  logic [DW-1:0]     rd_data;
  logic              unused_addr_bits;

  assign aw_hs = i_s_axi_awvalid & o_s_axi_awready;
  assign w_hs  = i_s_axi_wvalid & o_s_axi_wready;
  assign b_hs  = o_s_axi_bvalid & i_s_axi_bready;
  assign ar_hs = i_s_axi_arvalid & o_s_axi_arready;
  assign r_hs  = o_s_axi_rvalid & i_s_axi_rready;

  // A write commits on the edge where the later of AW/W is either already held or handshaking now.
  assign commit = (w_state == W_IDLE) && !i_sync_rst && (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_addr = aw_hs ? i_s_axi_awaddr : aw_addr_q;
  assign wr_data = w_hs ? i_s_axi_wdata : w_data_q;
  assign wr_strb = w_hs ? i_s_axi_wstrb : w_strb_q;

  assign unused_addr_bits = ^{wr_addr[OFS-1:0], i_s_axi_araddr[OFS-1:0]};

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int k = 0; k < N_REGS; k++) begin
      wr_sel[k] = (wr_addr[AW-1:OFS] == IDX_W'(k));
      rd_sel[k] = (i_s_axi_araddr[AW-1:OFS] == IDX_W'(k));
    end
  end

  assign wr_allowed = wr_sel & ~RO_MASK;
  assign wr_ok      = |wr_allowed;
  assign rd_ok      = |rd_sel;

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_state_next = W_RESP;
      W_RESP:  if (b_hs) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    o_s_axi_awready = (w_state == W_IDLE) && !aw_held && !i_sync_rst;
    o_s_axi_wready  = (w_state == W_IDLE) && !w_held && !i_sync_rst;
    o_s_axi_bvalid  = (w_state == W_RESP);
  end

  // Holding flags stay set through W_RESP so neither channel can be re-accepted before B completes.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (b_hs) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs) w_held <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (aw_hs) aw_addr_q <= i_s_axi_awaddr;
    if (w_hs) begin
      w_data_q <= i_s_axi_wdata;
      w_strb_q <= i_s_axi_wstrb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      o_s_axi_bresp <= RESP_OKAY;
      o_wr_pulse    <= '0;
    end else begin
      o_wr_pulse <= commit ? wr_allowed : '0;
      if (commit) o_s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_reg
    if (RO_MASK[k]) begin : g_ro
      assign o_regs[k*DW +: DW] = '0;
    end else begin : g_rw
      logic [DW-1:0] q;
      always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
          q <= RESET_VAL[k*DW +: DW];
        end else if (commit && wr_sel[k]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) q[b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
      assign o_regs[k*DW +: DW] = q;
    end
  end

  // Read mux sees the pre-commit register contents, so a same-edge read returns the old value.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (rd_sel[k]) rd_data = RO_MASK[k] ? i_ro_val[k*DW +: DW] : o_regs[k*DW +: DW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_next = R_RESP;
      R_RESP:  if (r_hs) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    o_s_axi_arready = (r_state == R_IDLE) && !i_sync_rst;
    o_s_axi_rvalid  = (r_state == R_RESP);
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      o_s_axi_rdata <= '0;
      o_s_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      o_s_axi_rdata <= rd_data;
      o_s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// Directed self-checking bench for axi4_lite_reg_file (16 x 32-bit, register 1 read-only).
module tb_axi4_lite_reg_file;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0002;
  localparam logic [NR*DW-1:0] RV = {{12{32'h0}}, 32'hFFFF_FFFF, 32'hA5A5_0000,
                                     32'hBBBB_BBBB, 32'h0000_1111};

  logic              clk;
  logic              rst;
  logic [AW-1:0]     awaddr;
  logic              awvalid, awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [AW-1:0]     araddr;
  logic              arvalid, arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid, rready;
  logic [NR*DW-1:0]  regs;
  logic [NR-1:0]     wr_pulse;
  logic [NR*DW-1:0]  ro_val;

  int n_compared;
  int n_mismatched;

  axi4_lite_reg_file #(
    .AXI4_LITE_ADDR_BIT_WIDTH(AW),
    .AXI4_LITE_DATA_BIT_WIDTH(DW),
    .N_REGS(NR),
    .RO_MASK(RO),
    .RESET_VAL(RV)
  ) dut (
    .i_clk(clk),
    .i_sync_rst(rst),
    .i_s_axi_awaddr(awaddr),
    .i_s_axi_awvalid(awvalid),
    .o_s_axi_awready(awready),
    .i_s_axi_wdata(wdata),
    .i_s_axi_wstrb(wstrb),
    .i_s_axi_wvalid(wvalid),
    .o_s_axi_wready(wready),
    .o_s_axi_bresp(bresp),
    .o_s_axi_bvalid(bvalid),
    .i_s_axi_bready(bready),
    .i_s_axi_araddr(araddr),
    .i_s_axi_arvalid(arvalid),
    .o_s_axi_arready(arready),
    .o_s_axi_rdata(rdata),
    .o_s_axi_rresp(rresp),
    .o_s_axi_rvalid(rvalid),
    .i_s_axi_rready(rready),
    .o_regs(regs),
    .o_wr_pulse(wr_pulse),
    .i_ro_val(ro_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] reg_at(input int k);
    return regs[k*DW +: DW];
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst     = 1'b1;
    awaddr  = '0; awvalid = 1'b0;
    wdata   = '0; wstrb   = '0; wvalid = 1'b0;
    bready  = 1'b0;
    araddr  = '0; arvalid = 1'b0;
    rready  = 1'b0;
    ro_val  = '0;
    ro_val[1*DW +: DW] = 32'h1234_5678;
    ro_val[0*DW +: DW] = 32'hFFFF_0000;

    // Reset state
    tick();
    tick();
    check_output("rst_awready", awready, 0);
    check_output("rst_wready", wready, 0);
    check_output("rst_arready", arready, 0);
    check_output("rst_bvalid", bvalid, 0);
    check_output("rst_rvalid", rvalid, 0);
    check_output("rst_bresp", bresp, 0);
    check_output("rst_rresp", rresp, 0);
    check_output("rst_rdata", rdata, 0);
    check_output("rst_pulse", wr_pulse, 0);
    check_output("rst_reg0", reg_at(0), 32'h0000_1111);
    check_output("rst_reg1_ro", reg_at(1), 0);
    check_output("rst_reg2", reg_at(2), 32'hA5A5_0000);
    check_output("rst_reg3", reg_at(3), 32'hFFFF_FFFF);
    rst = 1'b0;
    #1;
    check_output("post_rst_awready", awready, 1);
    check_output("post_rst_wready", wready, 1);
    check_output("post_rst_arready", arready, 1);

    // Read reset value of reg 2, then RO reg 1
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check_output("rd08_rvalid", rvalid, 1);
    check_output("rd08_rdata", rdata, 32'hA5A5_0000);
    check_output("rd08_rresp", rresp, 0);
    tick();
    check_output("rd08_rvalid_drop", rvalid, 0);
    araddr = 32'h04; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check_output("rd04_rvalid", rvalid, 1);
    check_output("rd04_rdata", rdata, 32'h1234_5678);
    check_output("rd04_rresp", rresp, 0);
    tick();

    // Strobed write to reg 3
    awaddr = 32'h0C; awvalid = 1'b1;
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_output("strb_bvalid", bvalid, 1);
    check_output("strb_bresp", bresp, 0);
    check_output("strb_reg3", reg_at(3), 32'hFF22_FF44);
    check_output("strb_pulse", wr_pulse, 16'h0008);
    check_output("strb_awready_resp", awready, 0);
    bready = 1'b1;
    tick();
    check_output("strb_pulse_clear", wr_pulse, 0);
    check_output("strb_bvalid_drop", bvalid, 0);

    // W three cycles before AW
    wdata = 32'hCAFE_BABE; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check_output("wfirst_wready_held", wready, 0);
    check_output("wfirst_awready", awready, 1);
    tick();
    tick();
    check_output("wfirst_no_bvalid", bvalid, 0);
    check_output("wfirst_no_pulse", wr_pulse, 0);
    awaddr = 32'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_output("wfirst_bvalid", bvalid, 1);
    check_output("wfirst_reg5", reg_at(5), 32'hCAFE_BABE);
    check_output("wfirst_pulse", wr_pulse, 16'h0020);
    tick();
    check_output("wfirst_bvalid_drop", bvalid, 0);
    check_output("wfirst_pulse_once", wr_pulse, 0);

    // AW and W together
    awaddr = 32'h18; awvalid = 1'b1;
    wdata = 32'h600D_F00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_output("same_bvalid", bvalid, 1);
    check_output("same_reg6", reg_at(6), 32'h600D_F00D);
    check_output("same_pulse", wr_pulse, 16'h0040);
    check_output("same_awready", awready, 0);
    check_output("same_wready", wready, 0);
    tick();

    // AW first, then a zero-strobe write: no data change but still a pulse
    awaddr = 32'h1C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_output("awfirst_awready_held", awready, 0);
    check_output("awfirst_wready", wready, 1);
    check_output("awfirst_no_bvalid", bvalid, 0);
    wdata = 32'hFFFF_FFFF; wstrb = 4'h0; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check_output("strb0_bvalid", bvalid, 1);
    check_output("strb0_bresp", bresp, 0);
    check_output("strb0_reg7", reg_at(7), 0);
    check_output("strb0_pulse", wr_pulse, 16'h0080);
    tick();

    // Out-of-range write
    awaddr = 32'h40; awvalid = 1'b1;
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_output("oor_bvalid", bvalid, 1);
    check_output("oor_bresp", bresp, 2'b10);
    check_output("oor_pulse", wr_pulse, 0);
    check_output("oor_reg0", reg_at(0), 32'h0000_1111);
    tick();

    // Write to read-only reg 1
    awaddr = 32'h04; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_output("ro_bvalid", bvalid, 1);
    check_output("ro_bresp", bresp, 2'b10);
    check_output("ro_pulse", wr_pulse, 0);
    check_output("ro_reg1", reg_at(1), 0);
    tick();

    // Out-of-range read
    araddr = 32'h40; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check_output("rdoor_rvalid", rvalid, 1);
    check_output("rdoor_rdata", rdata, 0);
    check_output("rdoor_rresp", rresp, 2'b10);
    tick();

    // Backpressure on B while reads of reg 0 stream; first read shares the commit edge
    bready = 1'b0;
    awaddr = 32'h00; awvalid = 1'b1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h00; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_output("bp_rvalid0", rvalid, 1);
    check_output("bp_rdata_old", rdata, 32'h0000_1111);
    check_output("bp_bvalid0", bvalid, 1);
    check_output("bp_reg0", reg_at(0), 32'hDEAD_BEEF);
    check_output("bp_pulse", wr_pulse, 16'h0001);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_output("bp_bvalid_hold", bvalid, 1);
      check_output("bp_bresp_hold", bresp, 0);
      check_output("bp_awready", awready, 0);
      check_output("bp_wready", wready, 0);
      check_output("bp_rvalid", rvalid, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) check_output("bp_rdata_new", rdata, 32'hDEAD_BEEF);
    end
    check_output("bp_pulse_gone", wr_pulse, 0);
    arvalid = 1'b0;
    bready = 1'b1;
    tick();
    check_output("bp_bvalid_drop", bvalid, 0);

    // Reset after AW captured but before W
    awaddr = 32'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_output("mid_awready_held", awready, 0);
    rst = 1'b1;
    #1;
    check_output("mid_rst_wready", wready, 0);
    check_output("mid_rst_arready", arready, 0);
    tick();
    check_output("mid_bvalid", bvalid, 0);
    check_output("mid_pulse", wr_pulse, 0);
    check_output("mid_rdata", rdata, 0);
    check_output("mid_reg0", reg_at(0), 32'h0000_1111);
    check_output("mid_reg5", reg_at(5), 0);
    rst = 1'b0;
    #1;
    check_output("mid_awready_free", awready, 1);
    wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check_output("mid_no_stale_commit", bvalid, 0);
    check_output("mid_reg2_kept", reg_at(2), 32'hA5A5_0000);
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_output("mid_fresh_bvalid", bvalid, 1);
    check_output("mid_fresh_bresp", bresp, 0);
    check_output("mid_fresh_reg2", reg_at(2), 32'h7777_7777);
    check_output("mid_fresh_pulse", wr_pulse, 16'h0004);
    tick();
    check_output("mid_fresh_bvalid_drop", bvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_file.md
# axi4_lite_reg_file

AXI4-Lite slave register file with a parametrised register count, data width, per-register read-only mask and reset values. It generalises the fixed single-width register definition in the register-model package into synthesizable storage that the UVM register model drives over AXI4-Lite. It sits between the AXI4-Lite interconnect and user logic: it exposes writable registers as flat outputs, samples hardware status for read-only registers, and pulses a per-register strobe on every accepted write.

## Interface
- AXI4_LITE_ADDR_BIT_WIDTH, 32, byte address width.
- AXI4_LITE_DATA_BIT_WIDTH, 32, data width; 32 or 64.
- N_REGS, 16, number of registers; must be ≥1 and N_REGS*bytes ≤ 2^ADDR width.
- RO_MASK, '0, N_REGS bits; bit k=1 makes register k read-only.
- RESET_VAL, '0, N_REGS*DATA bits; register k reset value in slice k.
- i_clk  in  1  clock.
- i_sync_rst  in  1  reset; synchronous and active-high.
- i_s_axi_awaddr/awvalid/o_s_axi_awready: AW channel; awaddr is ADDR width.
- i_s_axi_wdata/wstrb/wvalid/o_s_axi_wready: W channel; wdata is DATA wide, wstrb is DATA/8 wide.
- o_s_axi_bresp (2)/bvalid, i_s_axi_bready: B channel.
- i_s_axi_araddr/arvalid/o_s_axi_arready: AR channel.
- o_s_axi_rdata (DATA)/rresp (2)/rvalid, i_s_axi_rready: R channel.
- o_regs  out  N_REGS*DATA  current register contents; RO slices read 0.
- o_wr_pulse  out  N_REGS  one-cycle strobe per committed write.
- i_ro_val  in  N_REGS*DATA  hardware values returned for RO registers.
- AxPROT is ignored and has no ports.

## Operation
- Decode: word index = addr >> log2(DATA/8); low byte-offset bits are ignored. An index ≥ N_REGS is out of range.
- Write FSM has two states, W_IDLE and W_RESP.
  - In W_IDLE, AW and W are captured independently into holding registers.
  - awready = W_IDLE & !aw_held; wready = W_IDLE & !w_held.
  - The cycle the later of the two handshakes completes (both may complete in the same cycle), the write commits at that clock edge and the FSM moves to W_RESP.
  - Commit, in range and writable: each byte lane with wstrb=1 is updated; o_wr_pulse[k]=1 for one cycle; bresp=OKAY (00).
  - Commit, wstrb=0 in range: no data change, pulse still fires, OKAY.
  - Commit, out of range or RO: no change, no pulse, bresp=SLVERR (10).
  - In W_RESP, bvalid=1 and bresp is held. On bvalid&bready, holding flags clear and the FSM returns to W_IDLE.
- Read FSM has two states, R_IDLE and R_RESP.
  - arready = R_IDLE.
  - On AR handshake, rdata/rresp are latched and the FSM moves to R_RESP.
  - Latched data: in range RW returns the stored value; RO returns i_ro_val sampled that cycle; out of range returns 0 with rresp=SLVERR.
  - In R_RESP, rvalid=1 and data is held. On rvalid&rready, the FSM returns to R_IDLE.
- Read and write paths are fully independent and may be active concurrently.

## Timing
- Reset (i_sync_rst high at an edge) produces the following state:
  - Both FSMs go to IDLE and holding flags clear.
  - All readies are forced 0 while reset is high.
  - bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, o_wr_pulse=0, o_regs=RESET_VAL (RO slices 0).
- Reset mid-transaction aborts it. A pending captured write does not commit.
- The first accept is possible in the cycle after reset deasserts.
- Write latency: bvalid rises 1 cycle after the later of the AW/W handshakes. o_regs and o_wr_pulse update on that same edge.
- Read latency: rvalid rises 1 cycle after the AR handshake.
- Max throughput is one write per 2 cycles and one read per 2 cycles, with bready/rready held high.
- A read accepted in the same cycle as a write commit to the same register returns the pre-write value.
- A stalled bready/rready holds the response stable indefinitely and blocks new accepts on that path only.

## Test plan
- Reset value and RO read: RESET_VAL slice 2 = 0xA5A5_0000, RO_MASK bit 1 set, i_ro_val slice 1 = 0x1234_5678.
  - Read 0x08 -> rdata=0xA5A5_0000, OKAY, 1-cycle latency.
  - Read 0x04 -> rdata=0x1234_5678, OKAY.
- Strobed write, DATA=32: reg 3 = 0xFFFF_FFFF; write 0x0C with wdata 0x1122_3344, wstrb 0101.
  - o_regs slice 3 = 0xFF22_FF44; o_wr_pulse = 0x0008 for exactly 1 cycle; bresp=OKAY.
- AW/W ordering: present W 3 cycles before AW, then present AW and W in the same cycle.
  - Both cases give a single commit and bvalid 1 cycle after the later handshake.
  - Ready deasserts after each individual capture.
- Errors, N_REGS=16: write 0x40 and write to RO register 1.
  - Both give bresp=SLVERR, no o_regs change, no pulse.
  - Read 0x40 -> rdata=0, SLVERR.
- Backpressure and concurrency: hold bready low for 5 cycles while reads of reg 0 stream.
  - bvalid and bresp stay stable; awready/wready stay 0; reads continue.
  - A read accepted at the commit edge returns the old value.
- Reset mid-operation: assert i_sync_rst after AW is captured but before W.
  - No commit occurs; all outputs return to reset values.
  - A fresh write after reset completes normally.
